// File: rtl/palette_out_if.sv
// CPU palette access bus ($3F00-$3F1F) between the PPU register block (master)
// and the palette output stage (slave).
`timescale 1ns/1ps
interface palette_out_if;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       cpu_dout_valid;

    modport master (
        output cpu_wr, cpu_rd, cpu_addr, cpu_din,
        input  cpu_dout, cpu_dout_valid
    );

    modport slave (
        input  cpu_wr, cpu_rd, cpu_addr, cpu_din,
        output cpu_dout, cpu_dout_valid
    );
endinterface

// File: rtl/palette_out.sv
// PPU pixel back-end: palette RAM lookup, greyscale/emphasis, and a two-clock
// registered pixel pipeline, plus CPU-side palette read/write access.
`timescale 1ns/1ps
module palette_out #(
    parameter int PIPE_LAT          = 2,
    parameter bit BACKDROP_OVERRIDE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4:0]   palette_idx,
    input  logic         frame_on,
    input  logic         render_en,
    input  logic [7:0]   ppumask,
    input  logic [8:0]   cycle,
    input  logic [8:0]   y,
    input  logic [13:0]  vaddr,
    palette_out_if.slave cpu,
    output logic [5:0]   pix_color,
    output logic [2:0]   pix_emph,
    output logic         pix_valid,
    output logic [7:0]   pix_x,
    output logic [7:0]   pix_y,
    output logic         line_start,
    output logic         frame_start
);

    function automatic logic [4:0] mirror(input logic [4:0] a);
        return (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
    endfunction

    logic [5:0] palette_mem [32];

    logic [4:0] pix_idx;
    logic [4:0] cpu_addr_m;
    logic       unused_bits;

    logic [5:0] s1_color_d, s1_color_q;
    logic       s1_valid_d, s1_valid_q;
    logic [7:0] s1_x_d, s1_x_q;
    logic [7:0] s1_y_d, s1_y_q;

    logic [5:0] pix_color_d, pix_color_q;
    logic [2:0] pix_emph_d, pix_emph_q;
    logic       pix_valid_d, pix_valid_q;
    logic [7:0] pix_x_d, pix_x_q;
    logic [7:0] pix_y_d, pix_y_q;
    logic       line_start_d, line_start_q;
    logic       frame_start_d, frame_start_q;

    logic [5:0] cpu_dout_d, cpu_dout_q;
    logic       cpu_dout_valid_d, cpu_dout_valid_q;

    assign cpu_addr_m  = mirror(cpu.cpu_addr);
    assign unused_bits = &{1'b0, vaddr[7:5], cycle[8], y[8], ppumask[4:1],
                           cpu.cpu_din[7:6], PIPE_LAT == 2};

    // Any index with [1:0]==0 shows the universal backdrop at entry 0x00.
    always_comb begin
        pix_idx = 5'h00;
        if (render_en) begin
            if (palette_idx[1:0] != 2'b00) begin
                pix_idx = palette_idx;
            end
        end else if (BACKDROP_OVERRIDE && (vaddr[13:8] == 6'h3F)) begin
            pix_idx = mirror(vaddr[4:0]);
        end
    end

    always_comb begin
        s1_color_d       = palette_mem[pix_idx];
        s1_valid_d       = frame_on;
        s1_x_d           = cycle[7:0] - 8'd1;
        s1_y_d           = y[7:0];

        pix_color_d      = s1_color_q & (ppumask[0] ? 6'h30 : 6'h3F);
        pix_emph_d       = ppumask[7:5];
        pix_valid_d      = s1_valid_q;
        pix_x_d          = s1_x_q;
        pix_y_d          = s1_y_q;
        line_start_d     = s1_valid_q && (s1_x_q == 8'd0);
        frame_start_d    = line_start_d && (s1_y_q == 8'd0);

        cpu_dout_d       = cpu_dout_q;
        cpu_dout_valid_d = 1'b0;
        // A write in the same cycle wins; the read is dropped without a pulse.
        if (cpu.cpu_rd && !cpu.cpu_wr) begin
            cpu_dout_d       = palette_mem[cpu_addr_m];
            cpu_dout_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_color_q       <= '0;
            s1_valid_q       <= 1'b0;
            s1_x_q           <= '0;
            s1_y_q           <= '0;
            pix_color_q      <= '0;
            pix_emph_q       <= '0;
            pix_valid_q      <= 1'b0;
            pix_x_q          <= '0;
            pix_y_q          <= '0;
            line_start_q     <= 1'b0;
            frame_start_q    <= 1'b0;
            cpu_dout_q       <= '0;
            cpu_dout_valid_q <= 1'b0;
        end else begin
            s1_color_q       <= s1_color_d;
            s1_valid_q       <= s1_valid_d;
            s1_x_q           <= s1_x_d;
            s1_y_q           <= s1_y_d;
            pix_color_q      <= pix_color_d;
            pix_emph_q       <= pix_emph_d;
            pix_valid_q      <= pix_valid_d;
            pix_x_q          <= pix_x_d;
            pix_y_q          <= pix_y_d;
            line_start_q     <= line_start_d;
            frame_start_q    <= frame_start_d;
            cpu_dout_q       <= cpu_dout_d;
            cpu_dout_valid_q <= cpu_dout_valid_d;
        end
    end

    // Palette contents survive reset; pixel reads in the write cycle see the old entry.
    always_ff @(posedge clk) begin
        if (cpu.cpu_wr) begin
            palette_mem[cpu_addr_m] <= cpu.cpu_din[5:0];
        end
    end

    assign pix_color          = pix_color_q;
    assign pix_emph           = pix_emph_q;
    assign pix_valid          = pix_valid_q;
    assign pix_x              = pix_x_q;
    assign pix_y              = pix_y_q;
    assign line_start         = line_start_q;
    assign frame_start        = frame_start_q;
    assign cpu.cpu_dout       = {2'b00, cpu_dout_q};
    assign cpu.cpu_dout_valid = cpu_dout_valid_q;

endmodule

// File: tb/tb_palette_out.sv
// Scoreboard bench for palette_out: a spec-level palette model predicts every
// output cycle; a monitor compares DUT outputs one clock at a time.
`timescale 1ns/1ps
module tb_palette_out;

    typedef struct packed {
        logic [4:0]  palette_idx;
        logic        frame_on;
        logic        render_en;
        logic [7:0]  ppumask;
        logic [8:0]  cycle;
        logic [8:0]  y;
        logic [13:0] vaddr;
        logic        cpu_wr;
        logic        cpu_rd;
        logic [4:0]  cpu_addr;
        logic [7:0]  cpu_din;
    } stim_t;

    typedef struct packed {
        logic       color_known;
        logic [5:0] pix_color;
        logic [2:0] pix_emph;
        logic       pix_valid;
        logic [7:0] pix_x;
        logic [7:0] pix_y;
        logic       line_start;
        logic       frame_start;
        logic [7:0] cpu_dout;
        logic       cpu_dout_valid;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  palette_idx;
    logic        frame_on;
    logic        render_en;
    logic [7:0]  ppumask;
    logic [8:0]  cycle;
    logic [8:0]  y;
    logic [13:0] vaddr;
    logic [5:0]  pix_color;
    logic [2:0]  pix_emph;
    logic        pix_valid;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic        line_start;
    logic        frame_start;

    palette_out_if cpu_bus ();

    palette_out #(
        .PIPE_LAT         (2),
        .BACKDROP_OVERRIDE(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .palette_idx(palette_idx),
        .frame_on   (frame_on),
        .render_en  (render_en),
        .ppumask    (ppumask),
        .cycle      (cycle),
        .y          (y),
        .vaddr      (vaddr),
        .cpu        (cpu_bus),
        .pix_color  (pix_color),
        .pix_emph   (pix_emph),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .line_start (line_start),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vectors     = 0;
    int   n_checks      = 0;
    int   n_miscompares = 0;
    bit   mon_en        = 1'b0;
    exp_t exp_q[$];

    // Reference model: palette contents plus the one pixel still in flight.
    int model_mem [32];
    bit model_known [32];
    int model_dout;
    int pend_raw;
    bit pend_known;
    bit pend_valid;
    int pend_x;
    int pend_y;

    function automatic int mirror(input int a);
        return (a % 4 == 0) ? a % 16 : a;
    endfunction

    function automatic stim_t idle();
        return '0;
    endfunction

    task automatic model_reset();
        model_dout = 0;
        pend_raw   = 0;
        pend_known = 1'b1;
        pend_valid = 1'b0;
        pend_x     = 0;
        pend_y     = 0;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        int   idx;
        int   mask;
        @(negedge clk);
        palette_idx      = s.palette_idx;
        frame_on         = s.frame_on;
        render_en        = s.render_en;
        ppumask          = s.ppumask;
        cycle            = s.cycle;
        y                = s.y;
        vaddr            = s.vaddr;
        cpu_bus.cpu_wr   = s.cpu_wr;
        cpu_bus.cpu_rd   = s.cpu_rd;
        cpu_bus.cpu_addr = s.cpu_addr;
        cpu_bus.cpu_din  = s.cpu_din;

        mask            = s.ppumask[0] ? 'h30 : 'h3F;
        e.color_known   = pend_known;
        e.pix_color     = 6'(pend_raw & mask);
        e.pix_emph      = s.ppumask[7:5];
        e.pix_valid     = pend_valid;
        e.pix_x         = 8'(pend_x);
        e.pix_y         = 8'(pend_y);
        e.line_start    = pend_valid && (pend_x == 0);
        e.frame_start   = e.line_start && (pend_y == 0);
        if (s.cpu_rd && !s.cpu_wr) begin
            model_dout       = model_mem[mirror(int'(s.cpu_addr))];
            e.cpu_dout_valid = 1'b1;
        end else begin
            e.cpu_dout_valid = 1'b0;
        end
        e.cpu_dout = 8'(model_dout);
        exp_q.push_back(e);

        if (s.render_en) begin
            idx = (int'(s.palette_idx) % 4 == 0) ? 0 : int'(s.palette_idx);
        end else if (int'(s.vaddr) / 256 == 'h3F) begin
            idx = mirror(int'(s.vaddr) % 32);
        end else begin
            idx = 0;
        end
        pend_raw   = model_mem[idx];
        pend_known = model_known[idx];
        pend_valid = s.frame_on;
        pend_x     = (int'(s.cycle) + 255) % 256;
        pend_y     = int'(s.y) % 256;

        if (s.cpu_wr) begin
            model_mem[mirror(int'(s.cpu_addr))]   = int'(s.cpu_din) % 64;
            model_known[mirror(int'(s.cpu_addr))] = 1'b1;
        end
        n_vectors++;
    endtask

    task automatic cpu_write_step(input int addr, input int data);
        stim_t s;
        s          = idle();
        s.cpu_wr   = 1'b1;
        s.cpu_addr = 5'(addr);
        s.cpu_din  = 8'(data);
        applyStimulus(s);
    endtask

    task automatic cpu_read_step(input int addr);
        stim_t s;
        s          = idle();
        s.cpu_rd   = 1'b1;
        s.cpu_addr = 5'(addr);
        applyStimulus(s);
    endtask

    task automatic pixel_step(input int idx, input int cyc, input int row, input logic [7:0] mask);
        stim_t s;
        s             = idle();
        s.render_en   = 1'b1;
        s.palette_idx = 5'(idx);
        s.frame_on    = 1'b1;
        s.cycle       = 9'(cyc);
        s.y           = 9'(row);
        s.ppumask     = mask;
        applyStimulus(s);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " pix_color"}, 16'(pix_color), 16'h0);
        checkOutput({tag, " pix_emph"}, 16'(pix_emph), 16'h0);
        checkOutput({tag, " pix_valid"}, 16'(pix_valid), 16'h0);
        checkOutput({tag, " pix_x"}, 16'(pix_x), 16'h0);
        checkOutput({tag, " pix_y"}, 16'(pix_y), 16'h0);
        checkOutput({tag, " line_start"}, 16'(line_start), 16'h0);
        checkOutput({tag, " frame_start"}, 16'(frame_start), 16'h0);
        checkOutput({tag, " cpu_dout"}, 16'(cpu_bus.cpu_dout), 16'h0);
        checkOutput({tag, " cpu_dout_valid"}, 16'(cpu_bus.cpu_dout_valid), 16'h0);
    endtask

    // Monitor: one expected output set per clock, compared just after the edge.
    initial begin
        exp_t m;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && exp_q.size() != 0) begin
                m = exp_q.pop_front();
                if (m.color_known) begin
                    checkOutput("pix_color", 16'(pix_color), 16'(m.pix_color));
                end
                checkOutput("pix_emph", 16'(pix_emph), 16'(m.pix_emph));
                checkOutput("pix_valid", 16'(pix_valid), 16'(m.pix_valid));
                checkOutput("pix_x", 16'(pix_x), 16'(m.pix_x));
                checkOutput("pix_y", 16'(pix_y), 16'(m.pix_y));
                checkOutput("line_start", 16'(line_start), 16'(m.line_start));
                checkOutput("frame_start", 16'(frame_start), 16'(m.frame_start));
                checkOutput("cpu_dout", 16'(cpu_bus.cpu_dout), 16'(m.cpu_dout));
                checkOutput("cpu_dout_valid", 16'(cpu_bus.cpu_dout_valid), 16'(m.cpu_dout_valid));
            end
        end
    end

    initial begin
        stim_t s;
        rst_n            = 1'b1;
        palette_idx      = '0;
        frame_on         = 1'b0;
        render_en        = 1'b0;
        ppumask          = '0;
        cycle            = '0;
        y                = '0;
        vaddr            = '0;
        cpu_bus.cpu_wr   = 1'b0;
        cpu_bus.cpu_rd   = 1'b0;
        cpu_bus.cpu_addr = '0;
        cpu_bus.cpu_din  = '0;
        for (int i = 0; i < 32; i++) begin
            model_mem[i]   = 0;
            model_known[i] = 1'b0;
        end
        model_reset();

        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 32; i++) begin
            cpu_write_step(i, (i * 7 + 3) % 64);
        end

        // Mirrored write at 0x10 lands in 0x00; 0x15 is its own entry.
        cpu_write_step('h10, 'h21);
        cpu_read_step('h00);
        @(posedge clk); #2;
        checkOutput("mirror rd data", 16'(cpu_bus.cpu_dout), 16'h21);
        checkOutput("mirror rd valid", 16'(cpu_bus.cpu_dout_valid), 16'h1);
        cpu_write_step('h05, 'h15);
        cpu_read_step('h15);
        cpu_read_step('h05);
        cpu_read_step('h00);

        cpu_write_step('h07, 'h2A);
        pixel_step('h07, 1, 0, 8'h00);
        pixel_step('h14, 2, 0, 8'h00);
        @(posedge clk); #2;
        checkOutput("first px color", 16'(pix_color), 16'h2A);
        checkOutput("first px x", 16'(pix_x), 16'h0);
        checkOutput("first px y", 16'(pix_y), 16'h0);
        checkOutput("first px line_start", 16'(line_start), 16'h1);
        checkOutput("first px frame_start", 16'(frame_start), 16'h1);
        applyStimulus(idle());
        @(posedge clk); #2;
        checkOutput("idx 0x14 color", 16'(pix_color), 16'h21);
        checkOutput("second px x", 16'(pix_x), 16'h1);
        checkOutput("second px line_start", 16'(line_start), 16'h0);

        cpu_write_step('h03, 'h2A);
        pixel_step('h03, 40, 9, 8'h00);
        s = idle();
        s.ppumask = 8'hE1;
        applyStimulus(s);
        @(posedge clk); #2;
        checkOutput("grey color", 16'(pix_color), 16'h20);
        checkOutput("grey emph", 16'(pix_emph), 16'h7);

        cpu_write_step('h0B, 'h11);
        s = idle();
        s.vaddr = 14'h3F0B;
        applyStimulus(s);
        s.vaddr = 14'h2000;
        applyStimulus(s);
        @(posedge clk); #2;
        checkOutput("backdrop color", 16'(pix_color), 16'h11);
        checkOutput("backdrop valid", 16'(pix_valid), 16'h0);
        applyStimulus(idle());
        @(posedge clk); #2;
        checkOutput("vaddr 0x2000 color", 16'(pix_color), 16'h21);

        // Write and pixel read of entry 0x01 in one cycle: old value first.
        cpu_write_step('h01, 'h05);
        s = idle();
        s.render_en   = 1'b1;
        s.palette_idx = 5'h01;
        s.frame_on    = 1'b1;
        s.cycle       = 9'd20;
        s.y           = 9'd3;
        s.cpu_wr      = 1'b1;
        s.cpu_addr    = 5'h01;
        s.cpu_din     = 8'h3F;
        applyStimulus(s);
        s.cpu_wr = 1'b0;
        s.cycle  = 9'd21;
        applyStimulus(s);
        @(posedge clk); #2;
        checkOutput("contention old", 16'(pix_color), 16'h05);
        applyStimulus(idle());
        @(posedge clk); #2;
        checkOutput("contention new", 16'(pix_color), 16'h3F);

        s = idle();
        s.cpu_wr   = 1'b1;
        s.cpu_rd   = 1'b1;
        s.cpu_addr = 5'h02;
        s.cpu_din  = 8'h0C;
        applyStimulus(s);
        @(posedge clk); #2;
        checkOutput("rd+wr no valid", 16'(cpu_bus.cpu_dout_valid), 16'h0);
        cpu_read_step('h02);
        cpu_read_step('h03);

        pixel_step('h06, 10, 5, 8'h00);
        pixel_step('h09, 11, 5, 8'h00);
        pixel_step('h0A, 12, 5, 8'h00);
        @(posedge clk); #3;
        checkOutput("pre-reset valid", 16'(pix_valid), 16'h1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1 check_all_zero("async reset");
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all_zero("held reset");
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        cpu_read_step('h07);
        @(posedge clk); #2;
        checkOutput("retained entry", 16'(cpu_bus.cpu_dout), 16'h2A);

        for (int i = 0; i < 1500; i++) begin
            s = idle();
            s.render_en   = ($urandom_range(0, 3) != 0);
            s.palette_idx = 5'($urandom);
            s.ppumask     = 8'($urandom);
            s.cycle       = ($urandom_range(0, 7) == 0) ? 9'd1 : 9'($urandom_range(0, 340));
            s.y           = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(0, 261));
            s.frame_on    = (s.cycle >= 9'd1) && (s.cycle <= 9'd256) && (s.y < 9'd240);
            s.vaddr       = ($urandom_range(0, 1) == 1) ? {6'h3F, 8'($urandom)} : 14'($urandom);
            s.cpu_wr      = ($urandom_range(0, 3) == 0);
            s.cpu_rd      = ($urandom_range(0, 2) == 0);
            s.cpu_addr    = 5'($urandom);
            s.cpu_din     = 8'($urandom);
            applyStimulus(s);
        end

        repeat (3) @(posedge clk);
        #2 checkOutput("scoreboard drained", 16'(exp_q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
